pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//  Inverse of the edge-pulse extractor: turns single-cycle event pulses back into timed levels.
//  Each of WIDTH channels drives level[i] high for hold_len cycles after a pulse[i].
//  It then emits a one-cycle done[i] when the level falls.
//  Sits in the USB driver between event/edge logic and level-sensitive consumers
//  (LED/status lines, resume/reset signalling windows, timeouts).
// PARAMETERS
//  WIDTH  5   number of independent channels
//  CNT_W  16  hold counter width; max hold = 2**CNT_W-1 cycles
// PORTS
//  clk       in   1         system clock, rising edge
//  rst_n     in   1         asynchronous, active-low reset
//  pulse     in   WIDTH     per-channel trigger, sampled every rising edge (level-sampled, not edge)
//  hold_len  in   CNT_W     hold length in cycles, shared; sampled only at an accepted trigger
//  level     out  WIDTH     stretched level, registered
//  done      out  WIDTH     1-cycle pulse on cycle level[i] first returns low, registered
//  overrun   out  WIDTH     1-cycle pulse: trigger ignored while busy, registered
//  busy      out  1         OR of level[], combinational from registers
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low: rst_n low clears all state at once.
//  - On reset: cnt[i]=0, level=0, done=0, overrun=0, busy=0.
//  - L = (hold_len==0) ? 1 : hold_len. A zero length is treated as 1.
//  - Per-channel states: IDLE (cnt==0) and ACTIVE (cnt!=0). level[i] is the registered ACTIVE state.
//  - IDLE, pulse[i]=1 sampled at edge k: cnt<=L.
//    level[i]=1 for cycles k+1..k+L exactly (latency 1, width L).
//    done[i]=1 only in cycle k+L+1.
//  - ACTIVE: cnt decrements by 1 per cycle.
//  - ACTIVE, cnt==1 (last high cycle) with pulse[i]=1: accepted as a back-to-back trigger in all builds.
//    cnt<=L, level stays high without a gap, done[i] is not emitted.
//  - ACTIVE, cnt>1 with pulse[i]=1: behaviour set by the CONFIGURATION macro below.
//  - pulse held high for N cycles is N triggers, evaluated cycle by cycle under the same rules.
//  - Channels are fully independent; simultaneous pulses on several channels are all honoured.
//  - hold_len changing while ACTIVE has no effect on the running count.
//  - Reset asserted mid-hold: level drops asynchronously, no done pulse. After rst_n rises, the channel is IDLE.
//  - No wrap: cnt never decrements below 0; L <= 2**CNT_W-1 by construction.
// CONFIGURATION
//  Macro PULSE_STRETCHER_RETRIG_EN:
//  - defined: a pulse while ACTIVE with cnt>1 reloads cnt<=L (retrigger).
//    The level extends, no done for the cut-short period, overrun is tied 0.
//  - undefined: a pulse while ACTIVE with cnt>1 is ignored.
//    cnt is unchanged and overrun[i]=1 in the following cycle.
// STRUCTURE
//  - Shared package usb_drv_pkg: constants PS_WIDTH_DEF=5, PS_CNT_W_DEF=16.
//    Also a localparam/enum for channel state IDLE/ACTIVE (1 bit, encoded as cnt!=0).
//  - Sub-module pulse_stretch_chan: one channel holding cnt, level, done and overrun.
//    Instantiated WIDTH times in a generate loop.
//  - Top level: generate loop, hold_len fan-out, L computation (shared), busy OR-reduce.
// TESTING
//  1. Reset: drive pulse=5'h1F during reset -> level=0, done=0, overrun=0, busy=0. Still 0 one cycle after release with pulse=0.
//  2. Basic: hold_len=3, pulse[0] for 1 cycle at edge k -> level[0] high k+1..k+3. done[0] at k+4 only; other channels stay 0.
//  3. hold_len=0: single pulse[2] -> level[2] high exactly 1 cycle, then done[2] the next cycle.
//  4. Back-to-back: hold_len=2, pulses at k and k+2 -> level[1] high k+1..k+4 without a gap. Single done at k+5.
//  5. Mid-hold pulse: hold_len=10, pulses at k and k+4.
//     RETRIG_EN defined -> level high k+1..k+14, done at k+15, overrun never set.
//     Undefined -> level high k+1..k+10, done at k+11, overrun[i] at k+5.
//  6. Async reset mid-hold: hold_len=100, drop rst_n 20 cycles in -> level clears at once, no done.
//     After release, a new pulse restarts a full 100-cycle hold.

Source files
------------

// File: rtl/usb_drv_pkg.sv
// Shared USB-driver constants and the pulse stretcher channel state type.
package usb_drv_pkg;

    localparam int PS_WIDTH_DEF = 5;
    localparam int PS_CNT_W_DEF = 16;

    // A channel is ACTIVE exactly when its hold counter is non-zero.
    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_t;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle between event logic (master) and the pulse stretcher (slave).
interface pulse_stretcher_if
    import usb_drv_pkg::*;
#(
    parameter int WIDTH = PS_WIDTH_DEF,
    parameter int CNT_W = PS_CNT_W_DEF
);

    logic [WIDTH-1:0] pulse;
    logic [CNT_W-1:0] hold_len;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] overrun;
    logic             busy;

    modport master (
        output pulse, hold_len,
        input  level, done, overrun, busy
    );

    modport slave (
        input  pulse, hold_len,
        output level, done, overrun, busy
    );

endinterface

// File: rtl/pulse_stretch_chan.sv
// One stretcher channel: hold counter with registered level, done and overrun flags.
// Build option PULSE_STRETCHER_RETRIG_EN: triggers while mid-hold reload instead of being flagged.
module pulse_stretch_chan
    import usb_drv_pkg::*;
#(
    parameter int CNT_W = PS_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic [CNT_W-1:0] len,
    output logic             level,
    output logic             done,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             done_next;
    logic             overrun_next;
    ch_state_t        state;

    assign state = (cnt != '0) ? CH_ACTIVE : CH_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            level   <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            level   <= (cnt_next != '0);
            done    <= done_next;
            overrun <= overrun_next;
        end
    end

    // A trigger on the last high cycle always chains seamlessly, so done only fires on a real fall.
    always_comb begin
        cnt_next     = cnt;
        done_next    = 1'b0;
        overrun_next = 1'b0;
        case (state)
            CH_IDLE: begin
                if (pulse) cnt_next = len;
            end
            CH_ACTIVE: begin
`ifdef PULSE_STRETCHER_RETRIG_EN
                if (pulse) begin
                    cnt_next = len;
                end else begin
                    cnt_next  = cnt - ONE;
                    done_next = (cnt == ONE);
                end
`else
                if (pulse && cnt == ONE) begin
                    cnt_next = len;
                end else begin
                    cnt_next     = cnt - ONE;
                    done_next    = (cnt == ONE);
                    overrun_next = pulse;
                end
`endif
            end
            default: cnt_next = '0;
        endcase
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: WIDTH independent channels sharing one hold length.
// Build option PULSE_STRETCHER_RETRIG_EN selects retrigger vs. overrun on mid-hold pulses.
module pulse_stretcher
    import usb_drv_pkg::*;
#(
    parameter int WIDTH = PS_WIDTH_DEF,
    parameter int CNT_W = PS_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_stretcher_if.slave  bus
);

    logic [CNT_W-1:0] eff_len;
    logic [WIDTH-1:0] level_vec;
    logic [WIDTH-1:0] done_vec;
    logic [WIDTH-1:0] overrun_vec;

    // A zero length would never leave IDLE sensibly, so it is promoted to one cycle.
    assign eff_len = (bus.hold_len == '0) ? CNT_W'(1) : bus.hold_len;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pulse_stretch_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .pulse   (bus.pulse[i]),
            .len     (eff_len),
            .level   (level_vec[i]),
            .done    (done_vec[i]),
            .overrun (overrun_vec[i])
        );
    end

    assign bus.level   = level_vec;
    assign bus.done    = done_vec;
    assign bus.overrun = overrun_vec;
    assign bus.busy    = |level_vec;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: directed scenarios plus random traffic against an end-time model.
module tb_pulse_stretcher;
    import usb_drv_pkg::*;

    localparam int W  = PS_WIDTH_DEF;
    localparam int CW = PS_CNT_W_DEF;
`ifdef PULSE_STRETCHER_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    pulse_stretcher_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

    pulse_stretcher #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel remembers the edge index at which its level falls.
    // Level after edge e is high iff e < end_edge; a trigger at edge e is a
    // fresh start or seamless chain iff e >= end_edge, otherwise mid-hold.
    int       edge_idx;
    int       end_edge [W];
    logic [W-1:0] exp_level;
    logic [W-1:0] exp_done;
    logic [W-1:0] exp_overrun;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s @edge %0d: got %0h expected %0h", tag, edge_idx, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < W; i++) end_edge[i] = 0;
        exp_level   = '0;
        exp_done    = '0;
        exp_overrun = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge and check all outputs.
    task automatic applyStimulus(input logic [W-1:0] p, input logic [CW-1:0] h);
        int len;
        logic [W-1:0] prev_level;
        bus_if.pulse    = p;
        bus_if.hold_len = h;
        @(posedge clk);
        edge_idx++;
        len = (h == 0) ? 1 : int'(h);
        prev_level  = exp_level;
        exp_overrun = '0;
        for (int i = 0; i < W; i++) begin
            if (p[i]) begin
                if (edge_idx >= end_edge[i] || RETRIG) end_edge[i] = edge_idx + len;
                else exp_overrun[i] = 1'b1;
            end
            exp_level[i] = (edge_idx < end_edge[i]);
        end
        exp_done = prev_level & ~exp_level;
        #1;
        checkOutput("level",   32'(bus_if.level),   32'(exp_level));
        checkOutput("done",    32'(bus_if.done),    32'(exp_done));
        checkOutput("overrun", 32'(bus_if.overrun), 32'(exp_overrun));
        checkOutput("busy",    32'(bus_if.busy),    32'(|exp_level));
    endtask

    task automatic idleCycles(input int n, input logic [CW-1:0] h);
        for (int c = 0; c < n; c++) applyStimulus('0, h);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        edge_idx     = 0;
        modelReset();

        // Reset with every trigger asserted: outputs must stay clear.
        rst_n           = 1'b0;
        bus_if.pulse    = 5'h1F;
        bus_if.hold_len = 16'd4;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level",   32'(bus_if.level),   32'h0);
        checkOutput("rst_done",    32'(bus_if.done),    32'h0);
        checkOutput("rst_overrun", 32'(bus_if.overrun), 32'h0);
        checkOutput("rst_busy",    32'(bus_if.busy),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('0, 16'd4);
        checkOutput("post_rst_level", 32'(bus_if.level), 32'h0);

        // Basic hold of 3 on channel 0.
        applyStimulus(5'b00001, 16'd3);
        idleCycles(5, 16'd3);

        // Zero length behaves as one cycle on channel 2.
        applyStimulus(5'b00100, 16'd0);
        idleCycles(3, 16'd0);

        // Back-to-back trigger on the last high cycle of channel 1.
        applyStimulus(5'b00010, 16'd2);
        applyStimulus(5'b00000, 16'd2);
        applyStimulus(5'b00010, 16'd2);
        idleCycles(4, 16'd2);

        // Mid-hold trigger on channel 4, with hold_len changing while active.
        applyStimulus(5'b10000, 16'd10);
        idleCycles(3, 16'd7);
        applyStimulus(5'b10000, 16'd10);
        idleCycles(14, 16'd3);

        // Simultaneous triggers on all channels, then a held pulse.
        applyStimulus(5'h1F, 16'd4);
        idleCycles(6, 16'd4);
        for (int c = 0; c < 6; c++) applyStimulus(5'b01000, 16'd2);
        idleCycles(4, 16'd2);

        // Asynchronous reset in the middle of a long hold.
        applyStimulus(5'b01000, 16'd100);
        idleCycles(19, 16'd100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_level", 32'(bus_if.level), 32'h0);
        checkOutput("async_rst_busy",  32'(bus_if.busy),  32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('0, 16'd100);
        applyStimulus(5'b01000, 16'd100);
        idleCycles(101, 16'd100);

        // Random traffic with sparse triggers and short lengths.
        for (int c = 0; c < 600; c++) begin
            logic [W-1:0]  p;
            logic [CW-1:0] h;
            for (int i = 0; i < W; i++) p[i] = ($urandom_range(0, 5) == 0);
            h = CW'($urandom_range(0, 12));
            applyStimulus(p, h);
        end
        idleCycles(15, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
